// File: rtl/ksa16b_sub_pipe.sv
// ksa16b_sub_pipe: 3-stage pipelined 16-bit Kogge-Stone subtractor, diff = a - b - bin.
// The sum is formed as a + ~b + ~bin, so borrow-out is the inverted carry-out.
// Optional flags: define KSA_SUB_FLAGS_EN to compute zero/ovf; otherwise they read 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, bin)
//   out_valid/ out_ready result handshake (diff, bout, zero, ovf)
//
// Stages: S1 = prefix levels 1-2, S2 = levels 3-4, S3 = sum/borrow/flags (drives outputs).
// in_ready is combinational from out_ready through the per-stage advance chain.
module ksa16b_sub_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic        zero,
    output logic        ovf
);
    localparam int unsigned W = 16;

    // One Kogge-Stone level: bit i absorbs the group ending at bit i-span.
    // Bits below span pass through (shifted-in zeros / forced-one mask).
    function automatic logic [2*W-1:0] ks_level(input logic [W-1:0] g,
                                                input logic [W-1:0] p,
                                                input int unsigned  span);
        logic [W-1:0] go;
        logic [W-1:0] po;
        go = g | (p & (g << span));
        po = p & ((p << span) | ~({W{1'b1}} << span));
        return {go, po};
    endfunction

    // Stage valid bits
    logic v1_q, v2_q, v3_q;
    logic v1_d, v2_d, v3_d;
    logic adv1, adv2;
    logic ld1, ld2, ld3;

    // S1 payload
    logic [W-1:0] g1_q, p1_q, pb1_q;
    logic         bin1_q;
    logic [W-1:0] g1_d, p1_d, g0, p0, gl1, pl1;

    // S2 payload
    logic [W-1:0] g2_q, p2_q, pb2_q;
    logic         bin2_q;
    logic [W-1:0] g2_d, p2_d, gl3, pl3;

    // S3 payload (registered outputs)
    logic [W-1:0] diff_q, diff_d;
    logic         bout_q, bout_d;
    logic [W-1:0] grp_c;
    logic         cin;

`ifdef KSA_SUB_FLAGS_EN
    logic a15_1_q, b15_1_q, a15_2_q, b15_2_q;
    logic zero_q, ovf_q, zero_d, ovf_d;
`endif

    // Handshake chain: each stage may load if it is empty or draining this cycle.
    assign adv2      = !v3_q | out_ready;
    assign adv1      = !v2_q | adv2;
    assign in_ready  = !v1_q | adv1;
    assign out_valid = v3_q;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (in_ready) v1_d = in_valid;
        if (adv1)     v2_d = v1_q;
        if (adv2)     v3_d = v2_q;
        ld1 = in_valid & in_ready;
        ld2 = v1_q & adv1;
        ld3 = v2_q & adv2;
    end

    // Prefix levels 1-2 on the incoming operands (subtrahend inverted).
    always_comb begin
        g0 = a & ~b;
        p0 = a ^ ~b;
        {gl1, pl1}  = ks_level(g0, p0, 1);
        {g1_d, p1_d} = ks_level(gl1, pl1, 2);
    end

    // Prefix levels 3-4: G/P now span bits [i:0].
    always_comb begin
        {gl3, pl3}   = ks_level(g1_q, p1_q, 4);
        {g2_d, p2_d} = ks_level(gl3, pl3, 8);
    end

    // Carry into bit i is the group carry out of bit i-1; carry-in is ~bin.
    always_comb begin
        cin    = ~bin2_q;
        grp_c  = g2_q | (p2_q & {W{cin}});
        diff_d = pb2_q ^ {grp_c[W-2:0], cin};
        bout_d = ~grp_c[W-1];
`ifdef KSA_SUB_FLAGS_EN
        zero_d = (diff_d == '0);
        ovf_d  = (a15_2_q ^ b15_2_q) & (a15_2_q ^ diff_d[W-1]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
        end
    end

    // Payload registers load only when their stage advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g1_q   <= '0;
            p1_q   <= '0;
            pb1_q  <= '0;
            bin1_q <= 1'b0;
            g2_q   <= '0;
            p2_q   <= '0;
            pb2_q  <= '0;
            bin2_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
`ifdef KSA_SUB_FLAGS_EN
            a15_1_q <= 1'b0;
            b15_1_q <= 1'b0;
            a15_2_q <= 1'b0;
            b15_2_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            if (ld1) begin
                g1_q   <= g1_d;
                p1_q   <= p1_d;
                pb1_q  <= p0;
                bin1_q <= bin;
`ifdef KSA_SUB_FLAGS_EN
                a15_1_q <= a[W-1];
                b15_1_q <= b[W-1];
`endif
            end
            if (ld2) begin
                g2_q   <= g2_d;
                p2_q   <= p2_d;
                pb2_q  <= pb1_q;
                bin2_q <= bin1_q;
`ifdef KSA_SUB_FLAGS_EN
                a15_2_q <= a15_1_q;
                b15_2_q <= b15_1_q;
`endif
            end
            if (ld3) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
`ifdef KSA_SUB_FLAGS_EN
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef KSA_SUB_FLAGS_EN
    assign zero = zero_q;
    assign ovf  = ovf_q;
`else
    assign zero = 1'b0;
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_ksa16b_sub_pipe.sv
// tb_ksa16b_sub_pipe: self-checking bench for ksa16b_sub_pipe.
// Inputs change on the falling edge; outputs are sampled there too. A queue of
// expected results (plain integer arithmetic) checks every output transfer in order.
`timescale 1ns/1ps
module tb_ksa16b_sub_pipe;
`ifdef KSA_SUB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] diff;
    logic        bout, zero, ovf;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [18:0] exp_q[$];
    logic [18:0] held;
    bit          acc, xfer, stalled;
    int          n_acc, n_out;

    always #5 clk = ~clk;

    ksa16b_sub_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Expected {ovf, zero, bout, diff} from integer arithmetic on the operands.
    function automatic logic [18:0] ref_model(input logic [15:0] ai, input logic [15:0] bi,
                                              input logic bi_n);
        int          d, s;
        logic [15:0] r;
        logic        brw, z, o;
        d   = int'(ai) - int'(bi) - int'(bi_n);
        brw = (d < 0);
        r   = 16'(d);
        s   = int'($signed(ai)) - int'($signed(bi)) - int'(bi_n);
        o   = (s > 32767) || (s < -32768);
        z   = (r == 16'h0000);
        if (!FLAGS) begin
            z = 1'b0;
            o = 1'b0;
        end
        return {o, z, brw, r};
    endfunction

    // One clock: sample handshakes just after the inputs settle, score, advance.
    task automatic cycle();
        #1;
        if (stalled)
            check("stall_hold", {12'b0, out_valid, ovf, zero, bout, diff}, {12'b0, 1'b1, held});
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'(0));
            else check("scoreboard", 32'({ovf, zero, bout, diff}), 32'(exp_q.pop_front()));
            n_out++;
        end
        if (acc) begin
            exp_q.push_back(ref_model(a, b, bin));
            n_acc++;
        end
        stalled = out_valid && !out_ready;
        held    = {ovf, zero, bout, diff};
        @(negedge clk);
    endtask

    // Beat offered into an empty pipe: captured at the first edge, out_valid after the third.
    task automatic send_one(input logic [15:0] ai, input logic [15:0] bi, input logic bi_n,
                            input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
        in_valid  = 1'b1;
        a         = ai;
        b         = bi;
        bin       = bi_n;
        out_ready = 1'b1;
        cycle();
        check("lat_accept", 32'(acc), 32'(1));
        in_valid = 1'b0;
        check("lat_edge1", 32'(out_valid), 32'(0));
        cycle();
        check("lat_edge2", 32'(out_valid), 32'(0));
        cycle();
        check("lat_edge3", 32'(out_valid), 32'(1));
        check("diff", 32'(diff), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
        check("zero", 32'(zero), 32'(FLAGS ? ez : 1'b0));
        check("ovf",  32'(ovf),  32'(FLAGS ? eo : 1'b0));
        cycle();
    endtask

    initial begin
        stalled = 1'b0;
        n_acc   = 0;
        n_out   = 0;

        // Reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_outputs",   32'({ovf, zero, bout, diff}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic corners
        send_one(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        send_one(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send_one(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        send_one(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        send_one(16'h1234, 16'h1233, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Backpressure: stream a=i, b=0 with the output stalled for six cycles
        n_acc     = 0;
        n_out     = 0;
        b         = '0;
        bin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            a = 16'(n_acc);
            cycle();
        end
        check("bp_accepts", 32'(n_acc), 32'(3));
        a = 16'(n_acc);
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'(0));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        check("bp_diff_hold", 32'(diff), 32'(16'h0000));
        out_ready = 1'b1;
        #1;
        check("bp_ready_same_cycle", 32'(in_ready), 32'(1));
        n_out = 0;
        for (int c = 0; c < 8; c++) begin
            a        = 16'(n_acc);
            in_valid = (n_acc < 8);
            cycle();
        end
        check("bp_outputs_8_cycles", 32'(n_out), 32'(8));
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        check("bp_drained", 32'(exp_q.size()), 32'(0));

        // Reset mid-flight with two beats held in the pipe
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 16'd9;  b = 16'd2; bin = 1'b0;
        cycle();
        a = 16'd20; b = 16'd5;
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();
        check("mid_out_valid", 32'(out_valid), 32'(1));
        check("mid_diff", 32'(diff), 32'(16'd7));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_diff", 32'(diff), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(1));
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            check("mid_no_stale", 32'(out_valid), 32'(0));
        end
        send_one(16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0);

        // Random stress with random valid/ready toggling
        n_acc = 0;
        n_out = 0;
        for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            bin       = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) cycle();
        check("rand_accepts", 32'(n_acc), 32'(10000));
        check("rand_outputs", 32'(n_out), 32'(n_acc));
        check("rand_queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
